// File: rtl/expr_eval_pkg.sv
// Shared encodings for the expression evaluator.
// State values line up with the legality checker.
package expr_eval_pkg;

  typedef enum logic [2:0] {
    ST_EMPTY  = 3'd0,
    ST_ERR    = 3'd1,
    ST_VAL    = 3'd2,
    ST_OPW    = 3'd3,
    ST_PEMPTY = 3'd4,
    ST_PVAL   = 3'd5,
    ST_POPW   = 3'd6
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } op_t;

  typedef enum logic [2:0] {
    C_ILL, C_DIG, C_OP, C_LP, C_RP
  } cls_t;

  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;
  localparam logic [7:0] CH_ADD = 8'h2B;
  localparam logic [7:0] CH_MUL = 8'h2A;
  localparam logic [7:0] CH_LP  = 8'h28;
  localparam logic [7:0] CH_RP  = 8'h29;

  function automatic cls_t classify(
    input logic [7:0] c
  );
    cls_t k;
    k = C_ILL;
    if (c >= CH_0 && c <= CH_9)
      k = C_DIG;
    else if (c == CH_ADD || c == CH_MUL)
      k = C_OP;
    else if (c == CH_LP)
      k = C_LP;
    else if (c == CH_RP)
      k = C_RP;
    return k;
  endfunction

endpackage

// File: rtl/expr_apply.sv
// Folds one factor into (S, T) under the pending operator.
// Purely combinational; carry/high product bits feed ovf.
module expr_apply
  import expr_eval_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] i_s,
  input  logic [W-1:0] i_t,
  input  logic         i_op,
  input  logic [W-1:0] i_f,
  output logic [W-1:0] o_s,
  output logic [W-1:0] o_t,
  output logic         o_ovf
);

  logic [W:0]     w_sum;
  logic [2*W-1:0] w_prod;

  always_comb begin
    w_sum  = {1'b0, i_s} + {1'b0, i_t};
    w_prod = {{W{1'b0}}, i_t} * {{W{1'b0}}, i_f};
    if (i_op == OP_MUL) begin
      o_s   = i_s;
      o_t   = w_prod[W-1:0];
      o_ovf = |w_prod[2*W-1:W];
    end else begin
      o_s   = w_sum[W-1:0];
      o_t   = i_f;
      o_ovf = w_sum[W];
    end
  end

endmodule

// File: rtl/expr_eval.sv
// Running evaluator for single-digit +,* expressions
// with one level of parentheses; one char per clk.
module expr_eval
  import expr_eval_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [7:0]   in,
  output logic         ok,
  output logic [W-1:0] value,
  output logic         ovf
);

  state_t       r_st, w_nst;
  logic [W-1:0] r_s, r_t, r_so, r_to;
  logic         r_op, r_opo, r_ovf;

  logic [W-1:0] w_ns, w_nt, w_nso, w_nto;
  logic         w_nop, w_nopo, w_novf;

  cls_t         w_cls;
  logic         w_rp;
  logic [W:0]   w_v;
  logic [W-1:0] w_dig;
  logic [W-1:0] w_as, w_at, w_af;
  logic         w_aop;
  logic [W-1:0] w_ps, w_pt;
  logic         w_povf;

  assign w_cls = classify(in);
  assign w_dig = {{(W-4){1'b0}}, in[3:0]};
  assign w_v   = {1'b0, r_s} + {1'b0, r_t};
  assign w_rp  = (r_st == ST_PVAL) && (w_cls == C_RP);

  // On ')' the inner sum is folded into the restored outer frame.
  assign w_as  = w_rp ? r_so : r_s;
  assign w_at  = w_rp ? r_to : r_t;
  assign w_aop = w_rp ? r_opo : r_op;
  assign w_af  = w_rp ? w_v[W-1:0] : w_dig;

  expr_apply #(.W(W)) u_apply (
    .i_s   (w_as),
    .i_t   (w_at),
    .i_op  (w_aop),
    .i_f   (w_af),
    .o_s   (w_ps),
    .o_t   (w_pt),
    .o_ovf (w_povf)
  );

  assign ok    = (r_st == ST_VAL);
  assign value = ok ? w_v[W-1:0] : '0;
  assign ovf   = r_ovf;

  always_comb begin
    w_nst  = ST_ERR;
    w_ns   = r_s;
    w_nt   = r_t;
    w_nop  = r_op;
    w_nso  = r_so;
    w_nto  = r_to;
    w_nopo = r_opo;
    w_novf = r_ovf | (ok & w_v[W]);
    unique case (r_st)
      ST_EMPTY, ST_OPW: begin
        unique case (1'b1)
          w_cls == C_DIG: begin
            w_nst  = ST_VAL;
            w_ns   = w_ps;
            w_nt   = w_pt;
            w_novf = w_novf | w_povf;
          end
          w_cls == C_LP: begin
            w_nst  = ST_PEMPTY;
            w_nso  = r_s;
            w_nto  = r_t;
            w_nopo = r_op;
            w_ns   = '0;
            w_nt   = '0;
            w_nop  = OP_ADD;
          end
          default: ;
        endcase
      end
      ST_VAL: begin
        if (w_cls == C_OP) begin
          w_nst = ST_OPW;
          w_nop = (in == CH_MUL) ? OP_MUL : OP_ADD;
        end
      end
      ST_PEMPTY, ST_POPW: begin
        if (w_cls == C_DIG) begin
          w_nst  = ST_PVAL;
          w_ns   = w_ps;
          w_nt   = w_pt;
          w_novf = w_novf | w_povf;
        end
      end
      ST_PVAL: begin
        unique case (1'b1)
          w_cls == C_OP: begin
            w_nst = ST_POPW;
            w_nop = (in == CH_MUL) ? OP_MUL : OP_ADD;
          end
          w_cls == C_RP: begin
            w_nst  = ST_VAL;
            w_ns   = w_ps;
            w_nt   = w_pt;
            w_nop  = r_opo;
            w_novf = w_novf | w_povf | w_v[W];
          end
          default: ;
        endcase
      end
      default: w_nst = ST_ERR;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_st  <= ST_EMPTY;
      r_s   <= '0;
      r_t   <= '0;
      r_op  <= OP_ADD;
      r_so  <= '0;
      r_to  <= '0;
      r_opo <= OP_ADD;
      r_ovf <= 1'b0;
    end else begin
      r_st  <= w_nst;
      r_s   <= w_ns;
      r_t   <= w_nt;
      r_op  <= w_nop;
      r_so  <= w_nso;
      r_to  <= w_nto;
      r_opo <= w_nopo;
      r_ovf <= w_novf;
    end
  end

endmodule

// File: tb/tb_expr_eval.sv
// Bench for expr_eval: directed vectors, W=8 overflow,
// async clear, and random streams against a grammar model.
module tb_expr_eval;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [7:0]  in16 = 8'h20;
  logic [7:0]  in8 = 8'h20;
  logic        ok16, ovf16, ok8, ovf8;
  logic [15:0] val16;
  logic [7:0]  val8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  expr_eval #(.W(16)) u16 (
    .clk(clk), .clr(clr), .in(in16),
    .ok(ok16), .value(val16), .ovf(ovf16)
  );

  expr_eval #(.W(8)) u8 (
    .clk(clk), .clr(clr), .in(in8),
    .ok(ok8), .value(val8), .ovf(ovf8)
  );

  typedef struct {
    bit         rst;
    logic [7:0] c;
    int         e;
  } vec_t;

  vec_t tv[$];

  function automatic void row(bit r, logic [7:0] c, int e);
    vec_t v;
    v.rst = r;
    v.c = c;
    v.e = e;
    tv.push_back(v);
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(logic [7:0] c16, logic [7:0] c8);
    @(negedge clk);
    in16 = c16;
    in8 = c8;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic chk16(string nm, int e, bit eovf);
    chk({nm, " ok"}, int'(ok16), (e >= 0) ? 1 : 0);
    chk({nm, " value"}, int'(val16), (e >= 0) ? e : 0);
    chk({nm, " ovf"}, int'(ovf16), int'(eovf));
  endtask

  task automatic feed_zero(string nm, string s);
    for (int i = 0; i < s.len(); i++) begin
      drive(s[i], 8'h20);
      chk({nm, " stays bad"}, int'(ok16), 0);
    end
  endtask

  localparam longint M = 65536;
  bit     m_err, m_ovf;
  int     m_dep, m_prev;
  longint m_s[2], m_t[2];
  bit     m_mul[2];

  function automatic void m_reset();
    m_err = 0;
    m_ovf = 0;
    m_dep = 0;
    m_prev = 0;
    for (int d = 0; d < 2; d++) begin
      m_s[d] = 0;
      m_t[d] = 0;
      m_mul[d] = 0;
    end
  endfunction

  function automatic void m_apply(int d, longint f);
    longint r;
    if (m_mul[d]) begin
      r = m_t[d] * f;
      if (r >= M) m_ovf = 1;
      m_t[d] = r % M;
    end else begin
      r = m_s[d] + m_t[d];
      if (r >= M) m_ovf = 1;
      m_s[d] = r % M;
      m_t[d] = f;
    end
  endfunction

  function automatic bit m_ok();
    return !m_err && m_dep == 0 && m_prev == 1;
  endfunction

  function automatic void m_step(logic [7:0] c);
    longint v;
    bit isd;
    if (m_ok() && m_s[0] + m_t[0] >= M) m_ovf = 1;
    isd = (c >= 8'h30 && c <= 8'h39);
    if (!m_err) begin
      if (isd && m_prev != 1) begin
        m_apply(m_dep, longint'(c) - 48);
        m_prev = 1;
      end else if ((c == 8'h2B || c == 8'h2A) && m_prev == 1) begin
        m_mul[m_dep] = (c == 8'h2A);
        m_prev = 2;
      end else if (c == 8'h28 && m_dep == 0 && m_prev != 1) begin
        m_dep = 1;
        m_s[1] = 0;
        m_t[1] = 0;
        m_mul[1] = 0;
        m_prev = 0;
      end else if (c == 8'h29 && m_dep == 1 && m_prev == 1) begin
        v = m_s[1] + m_t[1];
        if (v >= M) m_ovf = 1;
        m_dep = 0;
        m_apply(0, v % M);
        m_prev = 1;
      end else begin
        m_err = 1;
      end
    end
  endfunction

  function automatic logic [7:0] pick();
    string alph = "0123456789+*()x";
    int r = int'($urandom_range(0, 99));
    logic [7:0] dg;
    dg = (r % 3 == 0) ? 8'h39 : 8'(8'h30 + $urandom_range(0, 9));
    if (r < 10) return alph[$urandom_range(0, 14)];
    if (m_err) return dg;
    if (m_prev == 1) begin
      if (m_dep == 1 && r % 3 == 0) return 8'h29;
      return (r % 2 == 1) ? 8'h2A : 8'h2B;
    end
    if (m_dep == 0 && r % 7 == 0) return 8'h28;
    return dg;
  endfunction

  initial begin
    logic [7:0] c;
    int ev;

    row(1, 0, -1);
    row(0, "1", 1); row(0, "+", -1); row(0, "2", 3);
    row(0, "*", -1); row(0, "3", 7);
    row(1, 0, -1);
    row(0, "(", -1); row(0, "1", -1); row(0, "+", -1);
    row(0, "2", -1); row(0, ")", 3); row(0, "*", -1);
    row(0, "3", 9);
    row(1, 0, -1);
    row(0, "2", 2); row(0, "*", -1); row(0, "(", -1);
    row(0, "3", -1); row(0, "+", -1); row(0, "4", -1);
    row(0, ")", 14); row(0, "+", -1); row(0, "1", 15);
    row(1, 0, -1);
    row(0, "1", 1); row(0, "+", -1); row(0, "5", 6);
    row(1, 0, -1);
    row(0, "5", 5); row(0, "x", -1);

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].rst) begin
        do_reset();
      end else begin
        drive(tv[i].c, 8'h20);
      end
      chk16($sformatf("vec%0d", i), tv[i].e, 1'b0);
    end

    do_reset();
    drive("1", 8'h20);
    drive("+", 8'h20);
    drive("+", 8'h20);
    chk("1++ ok", int'(ok16), 0);
    feed_zero("1++2", "23+4*5+6*7");
    do_reset();
    drive("1", 8'h20);
    drive("2", 8'h20);
    chk("12 ok", int'(ok16), 0);
    feed_zero("12", "+3+4*5+6*7");
    do_reset();
    drive("(", 8'h20);
    drive("(", 8'h20);
    chk("(( ok", int'(ok16), 0);
    feed_zero("((1))", "1))+1+2*3+");

    do_reset();
    drive(8'h20, "9"); drive(8'h20, "*"); drive(8'h20, "9");
    chk("w8 81", int'(val8), 81);
    chk("w8 81 ovf", int'(ovf8), 0);
    drive(8'h20, "*"); drive(8'h20, "9");
    chk("w8 729 ok", int'(ok8), 1);
    chk("w8 729 value", int'(val8), 217);
    chk("w8 729 ovf", int'(ovf8), 1);
    drive(8'h20, "+"); drive(8'h20, "1");
    chk("w8 +1 value", int'(val8), 218);
    chk("w8 +1 ovf", int'(ovf8), 1);
    do_reset();
    chk("w8 clr ovf", int'(ovf8), 0);

    do_reset();
    drive("7", 8'h20);
    chk("async pre ok", int'(ok16), 1);
    #2 clr = 1'b1;
    #1;
    chk("async ok", int'(ok16), 0);
    chk("async value", int'(val16), 0);
    clr = 1'b0;
    drive("(", 8'h20); drive("1", 8'h20); drive("+", 8'h20);
    drive("2", 8'h20); drive("+", 8'h20); drive("0", 8'h20);
    #2 clr = 1'b1;
    #1;
    chk("pval ok", int'(ok16), 0);
    chk("pval value", int'(val16), 0);
    clr = 1'b0;
    drive("4", 8'h20);
    chk16("after clr 4", 4, 1'b0);

    for (int i = 0; i < 800; i++) begin
      if (i % 25 == 0) begin
        do_reset();
        m_reset();
      end
      c = pick();
      m_step(c);
      drive(c, 8'h20);
      ev = m_ok() ? int'((m_s[0] + m_t[0]) % M) : -1;
      chk16($sformatf("rnd%0d '%c'", i, c), ev, m_ovf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/expr_eval.md
Name: expr_eval

Overview:
- Expression evaluator that runs in parallel with, and directly downstream of, the expression legality checker.
- Consumes the same ASCII character stream, one character per clk. Grammar: single digits 0-9, binary `+` and `*`, at most one level of parentheses.
- Keeps a running numeric value of the expression received so far, using normal precedence (`*` binds tighter than `+`).
- Drives `ok` and `value` to the result/display stage.

Parameters:
- W, 16, datapath width. All arithmetic is modulo 2^W.

Ports:
- clk  input  1  clock, rising edge.
- clr  input  1  reset, asynchronous, active-high.
- in  input  8  ASCII character. One character is consumed on every rising clk edge while clr=0.
- ok  output  1  1 when the stream so far is a complete legal expression.
- value  output  W  value of the expression when ok=1; 0 when ok=0.
- ovf  output  1  sticky flag: some add or multiply exceeded 2^W-1.

Behaviour:
- Reset (clr=1, asynchronous): st=EMPTY; S=0; T=0; op=ADD; saved S_o=0, T_o=0, op_o=ADD; ovf=0. Outputs ok=0, value=0.
- Character classes:
  - DIG: "0".."9"; f = in-"0".
  - OP: "+" or "*".
  - LP: "(".
  - RP: ")".
  - everything else: illegal.
- Registers:
  - S = sum of completed terms.
  - T = value of the current term.
  - op = pending operator, applied to the next factor.
- Applying factor f:
  - op=ADD: S<=S+T, T<=f.
  - op=MUL: T<=T*f.
  - Initial state S=0, T=0, op=ADD gives value f for the first factor.
- States and transitions (any input not listed -> ERR):
  - EMPTY: DIG -> apply f, VAL. LP -> save (S,T,op) to (S_o,T_o,op_o); set S=0, T=0, op=ADD; go PEMPTY.
  - VAL: OP -> op<=(in=="*" ? MUL : ADD), go OPW.
  - OPW: DIG -> apply f, VAL. LP -> same as from EMPTY.
  - PEMPTY: DIG -> apply f (inner registers), PVAL.
  - PVAL:
    - OP -> set op, go POPW.
    - RP -> v=S+T; restore S_o, T_o, op_o; apply factor v; go VAL.
  - POPW: DIG -> apply f, PVAL.
  - ERR: absorbing; only clr leaves it.
  - Unused encodings -> ERR.
- Nesting: LP in PEMPTY, PVAL or POPW -> ERR. Depth is exactly 1.
- Multi-digit numbers are illegal: DIG directly after DIG -> ERR.
- Entering ERR leaves the arithmetic registers frozen.
- Outputs:
  - ok = (st==VAL), combinational from the state register.
  - value = ok ? (S+T) mod 2^W : 0.
  - Latency: the character sampled at edge k is reflected in ok/value immediately after edge k.
- Overflow:
  - ovf<=1 when any add or multiply performed at a clock edge produces a true result >= 2^W. This covers the apply-factor operations and the `)` restore/apply step.
  - The output sum S+T also sets ovf on the next edge if it wraps.
  - ovf clears only on clr. Overflow does not force ERR.
- Multiply: full W x W product, truncated to W bits. The upper bits are used only for ovf.
- Simultaneous events: clr has priority over any input character.
- Reset mid-operation: state and all arithmetic registers return to reset values immediately, regardless of state.

Decomposition:
- Shared package holds:
  - state encoding constants: EMPTY=0, ERR=1, VAL=2, OPW=3, PEMPTY=4, PVAL=5, POPW=6. These match the checker, so the two can be cross-checked.
  - op encoding: ADD=0, MUL=1.
  - ASCII constants for "0", "9", "+", "*", "(", ")".
- One natural sub-module: expr_apply, purely combinational.
  - Inputs: S, T, op, f.
  - Outputs: next S, next T, and an overflow bit.
  - It is instantiated once. Its f input is muxed between the digit value and the inner parenthesis value v.

Test Plan:
- "1+2*3" at W=16 -> after the 5th edge ok=1, value=7, ovf=0. After the 4th edge ok=0, value=0.
- "(1+2)*3" -> after the 5th edge (`)`) ok=1, value=3; after the 7th edge ok=1, value=9.
- "2*(3+4)+1" -> final ok=1, value=15. Mid-stream "2*(3+4)" gives value=14.
- "1++2", "12", "((1))", "1+" -> error cases:
  - "1++2", "12", "((1))" -> ok=0 from the offending character onward and stays 0 for 10 further legal characters.
  - "1+" -> ok=0 with no error state.
  - clr then "5" -> ok=1, value=5.
- W=8, "9*9*9" -> value=217, ovf=1. ovf stays 1 after a following "+1" (value=218). clr -> ovf=0.
- Assert clr asynchronously mid-clock in state PVAL with S=3 -> ok=0, value=0 without waiting for an edge. The next "4" gives value=4.
